// File: rtl/binary_to_bcd.sv
// Registered 14-bit binary to 4-digit packed BCD converter (double-dabble core, one output register stage).
// Build option: define BIN2BCD_SATURATE_EN to clamp out-of-range inputs to 16'h9999 instead of wrapping mod 10000.
module binary_to_bcd (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [13:0] binary_in,
   output logic        out_valid,
   output logic [15:0] packed_bcd_out,
   output logic        overflow
);

   logic        out_valid_q;
   logic [15:0] bcd_q;
   logic [15:0] bcd_d;
   logic        overflow_q;
   logic        overflow_d;
   logic [15:0] bcd_mod;

   // A 16-bit shift register silently drops the ten-thousands carry,
   // which is exactly binary_in mod 10000 with every nibble kept legal.
   always_comb begin
      bcd_mod = 16'h0000;
      for (int i = 13; i >= 0; i--) begin
         for (int d = 0; d < 4; d++) begin
            if (bcd_mod[4*d +: 4] >= 4'd5) begin
               bcd_mod[4*d +: 4] = bcd_mod[4*d +: 4] + 4'd3;
            end
         end
         bcd_mod = {bcd_mod[14:0], binary_in[i]};
      end
   end

   always_comb begin
      overflow_d = (binary_in > 14'd9999);
`ifdef BIN2BCD_SATURATE_EN
      bcd_d = overflow_d ? 16'h9999 : bcd_mod;
`else
      bcd_d = bcd_mod;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bcd_q       <= 16'h0000;
         overflow_q  <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign packed_bcd_out = bcd_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed self-checking bench for binary_to_bcd: sweep, overflow, hold, reset and digit boundaries.
module tb_binary_to_bcd;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [13:0] binary_in;
   logic        out_valid;
   logic [15:0] packed_bcd_out;
   logic        overflow;

   int checks;
   int failures;

   binary_to_bcd dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .binary_in      (binary_in),
      .out_valid      (out_valid),
      .packed_bcd_out (packed_bcd_out),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_bcd(input int v);
      int m;
`ifdef BIN2BCD_SATURATE_EN
      if (v > 9999) return 16'h9999;
`endif
      m = v % 10000;
      return 16'((((m / 1000) % 10) << 12) | (((m / 100) % 10) << 8) |
                 (((m / 10) % 10) << 4) | (m % 10));
   endfunction

   function automatic logic nibbles_legal(input logic [15:0] b);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (b[4*d +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic check_result(input string tag, input int v);
      chk({tag, "_bcd"}, 32'(packed_bcd_out), 32'(exp_bcd(v)));
      chk({tag, "_ovf"}, 32'(overflow), (v > 9999) ? 32'd1 : 32'd0);
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_nib"}, 32'(nibbles_legal(packed_bcd_out)), 32'd1);
   endtask

   task automatic convert(input string tag, input int v);
      in_valid  = 1'b1;
      binary_in = 14'(v);
      step();
      check_result(tag, v);
   endtask

   int bounds [6]     = '{9, 10, 99, 100, 999, 1000};
   logic [15:0] bexp [6] = '{16'h0009, 16'h0010, 16'h0099, 16'h0100, 16'h0999, 16'h1000};

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      binary_in = 14'd0;
      step();
      step();
      chk("rst_bcd", 32'(packed_bcd_out), 32'h0000);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_vld", 32'(out_valid), 32'd0);
      rst_n = 1'b1;

      // Hand-computed anchors before the sweep.
      convert("v1234", 1234);
      chk("v1234_lit", 32'(packed_bcd_out), 32'h1234);
      convert("v9999", 9999);
      chk("v9999_lit", 32'(packed_bcd_out), 32'h9999);

      for (int i = 0; i < 6; i++) begin
         convert("bound", bounds[i]);
         chk("bound_lit", 32'(packed_bcd_out), 32'(bexp[i]));
      end

      for (int v = 0; v <= 9999; v++) begin
         convert("sweep", v);
      end

      convert("o10000", 10000);
      convert("o16383", 16383);
`ifdef BIN2BCD_SATURATE_EN
      chk("o16383_lit", 32'(packed_bcd_out), 32'h9999);
`else
      chk("o16383_lit", 32'(packed_bcd_out), 32'h6383);
`endif
      chk("o16383_ovf_lit", 32'(overflow), 32'd1);
      convert("o12345", 12345);

      // Hold: output must freeze while in_valid is low.
      convert("hold_src", 4321);
      in_valid  = 1'b0;
      binary_in = 14'd55;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("hold_bcd", 32'(packed_bcd_out), 32'h4321);
         chk("hold_vld", 32'(out_valid), 32'd0);
         chk("hold_ovf", 32'(overflow), 32'd0);
      end

      // Overflow flag also holds.
      convert("hold_ovf_src", 16000);
      in_valid = 1'b0;
      step();
      chk("hold2_ovf", 32'(overflow), 32'd1);
      chk("hold2_bcd", 32'(packed_bcd_out), 32'(exp_bcd(16000)));

      // Reset beats a simultaneous valid input.
      convert("pre_rst", 8765);
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      binary_in = 14'd42;
      step();
      chk("rst2_bcd", 32'(packed_bcd_out), 32'h0000);
      chk("rst2_ovf", 32'(overflow), 32'd0);
      chk("rst2_vld", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_bcd", 32'(packed_bcd_out), 32'h0042);
      chk("post_rst_vld", 32'(out_valid), 32'd1);
      chk("post_rst_ovf", 32'(overflow), 32'd0);
      in_valid = 1'b0;
      step();
      chk("tail_vld", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
